systolic_sched_ctrl: RTL and testbench
======================================

// Module: systolic_sched_ctrl
// PURPOSE
//  Sequencer for the N x N output-stationary MAC array. One start runs one tile:
//  - clears the array accumulators;
//  - reads K column/row vector pairs (A column k, B row k) from the operand buffer;
//  - skews them onto a_rows/b_columns, waits for the array to drain, then pulses done.
//  Sits between the operand buffers and the MAC array; c_array is read externally after done.
// PARAMETERS
//  MAX_K_P    256  maximum inner dimension; K_W = $clog2(MAX_K_P+1)
//  MAC_LAT_P  1    MAC register latency from a/b at array edge to c update
// PORTS
//  clock_i         in   1            system clock
//  resetn_i        in   1            system reset, asynchronous, active low
//  start_i         in   1            start tile; sampled only in IDLE
//  k_len_i         in   K_W          inner dimension K, sampled with start_i, 0..MAX_K_P
//  busy_o          out  1            high from the cycle after accepted start until done_o inclusive
//  done_o          out  1            one-cycle pulse: c_array final and stable
//  mem_rd_en_o     out  1            operand buffer read strobe
//  mem_rd_addr_o   out  K_W          operand index k, 0..K-1
//  a_col_i         in   N x t_mac_data  A[.,k], returned exactly 1 cycle after rd_en
//  b_row_i         in   N x t_mac_data  B[k,.], returned exactly 1 cycle after rd_en
//  mac_clear_o     out  1            synchronous clear of all array accumulators
//  a_rows_o        out  N x t_mac_data  skewed array row inputs
//  b_columns_o     out  N x t_mac_data  skewed array column inputs
// BEHAVIOUR
//  Reset: state IDLE; counters 0; all outputs 0; skew lines 0. Asynchronous assert, synchronous effect on release.
//  FSM: IDLE -(start_i)-> CLEAR -> FEED -> DRAIN -> DONE -> IDLE. If K=0: CLEAR -> DONE.
//  IDLE:  busy_o=0.
//  CLEAR: mac_clear_o=1 for exactly 1 cycle.
//  FEED:  K cycles, mem_rd_en_o=1, addr = 0,1,..,K-1.
//  Skew:
//   - Data valid flag is rd_en delayed 1 cycle; invalid cycles inject 0.
//   - Lane r of A and lane c of B are delayed r and c cycles (zero-filled shift lines).
//   - Lane 0 is undelayed: a_rows_o[0] = a_col_i[0] in the cycle it returns.
//  DRAIN: counter runs 2*(N-1)+1+MAC_LAT_P cycles after the last rd_en cycle,
//   covering read latency, max skew N-1 and propagation N-1. Zeros only.
//  DONE: done_o=1 for 1 cycle, then IDLE. c_array holds until next CLEAR.
//  start_i outside IDLE: ignored, no queueing.
//  k_len_i > MAX_K_P: saturated to MAX_K_P.
//  Total start->done: 1 + K + DRAIN + 1 cycles.
//  Reset mid-tile: immediate return to IDLE; skew lines flushed to 0; no done_o.
//  mac_clear_o is never asserted concurrently with non-zero a_rows_o/b_columns_o.
// CONFIGURATION
//  SYSTOLIC_PERF_CNT_EN defined:
//   - adds cycles_o out 32: cycles of last tile, CLEAR through DONE inclusive;
//   - updated on done_o, reset 0.
//  Undefined: port and counter absent; functionality otherwise identical.
// STRUCTURE
//  Package systolic_pkg holds:
//   - t_mac_data, t_mac_mul_data, systolic_size_c (=N);
//   - t_sched_state enum {IDLE,CLEAR,FEED,DRAIN,DONE};
//   - drain-length constant function.
//  Sub-module systolic_skew_line (param DEPTH, DEPTH=0 -> wire).
//  Instantiated 2*N times by generate.
// TESTING
//  N=4, K=1, A col=1..4, B row=1..4 -> done 1+1+8+1 cycles after start; c[i][j]=(i+1)(j+1).
//  K=4, A=identity, B=random -> c_array == B at done_o. a_rows_o[3] first non-zero 4 cycles after first rd_en.
//  K=0 -> mac_clear_o pulse, done_o next cycle; no rd_en; c all 0.
//  start_i held high through the tile -> exactly one tile, second tile starts the cycle after return to IDLE.
//  resetn_i low in mid-FEED -> all outputs 0 same cycle; no done_o; a fresh start completes correctly.
//  With SYSTOLIC_PERF_CNT_EN, K=8 -> cycles_o=1+8+8+1=18 after done_o.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic MAC array scheduler.
package systolic_pkg;

  localparam int systolic_size_c = 4;

  typedef logic [7:0]  t_mac_data;
  typedef logic [15:0] t_mac_mul_data;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } t_sched_state;

  // Read latency (1) + worst skew (n-1) + propagation (n-1) + MAC register latency.
  function automatic int drain_len_f(input int n, input int mac_lat);
    return 2 * (n - 1) + 1 + mac_lat;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Zero-filled delay line of DEPTH register stages; DEPTH=0 is a plain wire.
module systolic_skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 8
) (
  input  logic         clock_i,
  input  logic         resetn_i,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clock_i ^ resetn_i;
    assign dout = din;
  end else begin : g_regs
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_sched_ctrl.sv
// Tile sequencer for the N x N output-stationary MAC array: clear, feed K skewed
// operand pairs, drain, pulse done. Optional SYSTOLIC_PERF_CNT_EN adds cycles_o.
module systolic_sched_ctrl
  import systolic_pkg::*;
#(
  parameter  int MAX_K_P   = 256,
  parameter  int MAC_LAT_P = 1,
  localparam int K_W       = $clog2(MAX_K_P + 1),
  localparam int N         = systolic_size_c,
  localparam int W         = $bits(t_mac_data)
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [K_W-1:0]   k_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_rd_en_o,
  output logic [K_W-1:0]   mem_rd_addr_o,
  input  logic [N*W-1:0]   a_col_i,
  input  logic [N*W-1:0]   b_row_i,
  output logic             mac_clear_o,
  output logic [N*W-1:0]   a_rows_o,
  output logic [N*W-1:0]   b_columns_o,
`ifdef SYSTOLIC_PERF_CNT_EN
  output logic [31:0]      cycles_o,
`endif
  output logic [2:0]       dbg_state_o
);

  localparam int DRAIN_C = drain_len_f(N, MAC_LAT_P);
  localparam int D_W     = $clog2(DRAIN_C + 1);
  localparam int CNT_W   = (K_W > D_W) ? K_W : D_W;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_C - 1);

  // Handshake: start_i is a request taken only while IDLE (no ready/queueing);
  // done_o is a single-cycle completion pulse with no acknowledge.

  t_sched_state     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [K_W-1:0]   k_sat;
  logic [CNT_W-1:0] k_last;
  logic             rd_valid_q;

  assign k_sat  = (k_len_i > K_W'(MAX_K_P)) ? K_W'(MAX_K_P) : k_len_i;
  assign k_last = CNT_W'(k_q) - CNT_W'(1);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      rd_valid_q <= mem_rd_en_o;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          k_d     = k_sat;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = (k_q == '0) ? DONE : FEED;
      end
      FEED: begin
        if (cnt_q == k_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign mac_clear_o   = (state_q == CLEAR);
  assign mem_rd_en_o   = (state_q == FEED);
  assign mem_rd_addr_o = mem_rd_en_o ? cnt_q[K_W-1:0] : '0;
  assign dbg_state_o   = state_q;

  // Lane g of each operand is delayed g cycles; returned data is gated by the
  // delayed read strobe so idle cycles inject zeros.
  for (genvar g = 0; g < N; g++) begin : g_lane
    systolic_skew_line #(.DEPTH(g), .W(W)) u_skew_a (
      .clock_i  (clock_i),
      .resetn_i (resetn_i),
      .din      (rd_valid_q ? a_col_i[g*W +: W] : {W{1'b0}}),
      .dout     (a_rows_o[g*W +: W])
    );
    systolic_skew_line #(.DEPTH(g), .W(W)) u_skew_b (
      .clock_i  (clock_i),
      .resetn_i (resetn_i),
      .din      (rd_valid_q ? b_row_i[g*W +: W] : {W{1'b0}}),
      .dout     (b_columns_o[g*W +: W])
    );
  end

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      perf_cnt_q <= '0;
      cycles_o   <= '0;
    end else begin
      perf_cnt_q <= (state_q == IDLE) ? 32'd0 : perf_cnt_q + 32'd1;
      if (state_q == DONE) cycles_o <= perf_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_sched_ctrl.sv
// Directed bench for systolic_sched_ctrl with an operand buffer and MAC array model.
module tb_systolic_sched_ctrl;
  import systolic_pkg::*;

  localparam int N    = systolic_size_c;
  localparam int W    = 8;
  localparam int K_W  = 9;
  localparam int MAXK = 256;

  logic           clock_i = 1'b0;
  logic           resetn_i;
  logic           start_i;
  logic [K_W-1:0] k_len_i;
  logic           busy_o, done_o, mem_rd_en_o, mac_clear_o;
  logic [K_W-1:0] mem_rd_addr_o;
  logic [N*W-1:0] a_col_i, b_row_i, a_rows_o, b_columns_o;
  logic [2:0]     dbg_state_o;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0]    cycles_o;
`endif

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q [$];

  logic [7:0]  a_mem [MAXK][N];
  logic [7:0]  b_mem [MAXK][N];

  systolic_sched_ctrl dut (
    .clock_i       (clock_i),
    .resetn_i      (resetn_i),
    .start_i       (start_i),
    .k_len_i       (k_len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .a_col_i       (a_col_i),
    .b_row_i       (b_row_i),
    .mac_clear_o   (mac_clear_o),
    .a_rows_o      (a_rows_o),
    .b_columns_o   (b_columns_o),
`ifdef SYSTOLIC_PERF_CNT_EN
    .cycles_o      (cycles_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // operand buffer: data one cycle after the read strobe
  always_ff @(posedge clock_i) begin
    if (mem_rd_en_o) begin
      for (int r = 0; r < N; r++) begin
        a_col_i[r*W +: W] <= a_mem[mem_rd_addr_o][r];
        b_row_i[r*W +: W] <= b_mem[mem_rd_addr_o][r];
      end
    end
  end

  // output-stationary MAC array model
  logic [7:0]  ain [N][N];
  logic [7:0]  bin [N][N];
  logic [7:0]  pa  [N][N];
  logic [7:0]  pb  [N][N];
  logic [31:0] acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ain[i][0] = a_rows_o[i*W +: W];
      bin[0][i] = b_columns_o[i*W +: W];
      for (int j = 1; j < N; j++) begin
        ain[i][j] = pa[i][j-1];
        bin[j][i] = pb[j-1][i];
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j]  <= ain[i][j];
          pb[i][j]  <= bin[i][j];
          acc[i][j] <= mac_clear_o ? 32'd0 : acc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
        end
    end
  end

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input int k);
    logic [31:0] s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += 32'(a_mem[kk][i]) * 32'(b_mem[kk][j]);
        exp_q.push_back(s);
      end
  endtask

  task automatic check_c();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (exp_q.size() == 0) chk("c_queue_empty", 32'd1, 32'd0);
        else chk("c_array", acc[i][j], exp_q.pop_front());
      end
  endtask

  // driver: issue one start and watch the tile until done_o or budget expiry
  task automatic run_tile(input int k, input bit hold, input int budget,
                          output int lat, output int rd_cnt, output int clr_cnt,
                          output int first_rd, output int first_a3);
    @(negedge clock_i);
    start_i  = 1'b1;
    k_len_i  = K_W'(k);
    lat      = -1;
    rd_cnt   = 0;
    clr_cnt  = 0;
    first_rd = -1;
    first_a3 = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock_i);
      if (!hold) start_i = 1'b0;
      chk("busy_in_tile", busy_o, 1);
      if (mem_rd_en_o) begin
        chk("rd_addr", mem_rd_addr_o, rd_cnt);
        if (first_rd < 0) first_rd = i;
        rd_cnt++;
      end
      if (first_a3 < 0 && a_rows_o[3*W +: W] != 0) first_a3 = i;
      if (mac_clear_o) begin
        clr_cnt++;
        chk("clear_with_zero_data", {a_rows_o, b_columns_o} == 0, 1);
      end
      if (done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_rd_en"}, mem_rd_en_o, 0);
    chk({tag, "_addr"},  mem_rd_addr_o, 0);
    chk({tag, "_clear"}, mac_clear_o, 0);
    chk({tag, "_a_rows"}, a_rows_o, 0);
    chk({tag, "_b_cols"}, b_columns_o, 0);
    chk({tag, "_state"}, dbg_state_o, 0);
  endtask

  int lat, rd_cnt, clr_cnt, first_rd, first_a3, lat2, done_seen;
  bit found;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn_i = 1'b0;
    start_i  = 1'b0;
    k_len_i  = '0;
    for (int kk = 0; kk < MAXK; kk++)
      for (int r = 0; r < N; r++) begin
        a_mem[kk][r] = 8'($urandom_range(0, 15));
        b_mem[kk][r] = 8'($urandom_range(0, 15));
      end

    // reset state
    repeat (3) @(negedge clock_i);
    check_all_zero("reset");
    resetn_i = 1'b1;
    @(negedge clock_i);

    // K=1, A col = 1..4, B row = 1..4 -> c[i][j] = (i+1)(j+1), done 11 cycles after start
    for (int r = 0; r < N; r++) begin
      a_mem[0][r] = 8'(r + 1);
      b_mem[0][r] = 8'(r + 1);
    end
    push_expected(1);
    run_tile(1, 1'b0, 40, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("k1_latency", lat, 11);
    chk("k1_rd_count", rd_cnt, 1);
    chk("k1_clear_count", clr_cnt, 1);
    chk("k1_first_rd_cycle", first_rd, 2);
    chk("k1_a3_skew", first_a3 - first_rd, 4);
    chk("k1_c33", acc[3][3], 16);
    check_c();
    @(negedge clock_i);
    chk("k1_idle_busy", busy_o, 0);
    chk("k1_idle_done", done_o, 0);

    // K=4, A = identity, B random -> c == B
    for (int kk = 0; kk < 4; kk++)
      for (int r = 0; r < N; r++) begin
        a_mem[kk][r] = (kk == r) ? 8'd1 : 8'd0;
        b_mem[kk][r] = 8'($urandom_range(0, 255));
      end
    push_expected(4);
    run_tile(4, 1'b0, 40, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("k4_latency", lat, 14);
    chk("k4_rd_count", rd_cnt, 4);
    chk("k4_c_eq_b_12", acc[1][2], 32'(b_mem[1][2]));
    check_c();

    // K=0 -> clear then done the next cycle, no reads, c all zero
    push_expected(0);
    run_tile(0, 1'b0, 20, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("k0_latency", lat, 2);
    chk("k0_rd_count", rd_cnt, 0);
    chk("k0_clear_count", clr_cnt, 1);
    check_c();

    // start held high: one tile, then the next starts right after one IDLE cycle
    for (int r = 0; r < N; r++) begin
      a_mem[0][r] = 8'(r + 1);
      b_mem[0][r] = 8'(4 - r);
    end
    push_expected(1);
    push_expected(1);
    run_tile(1, 1'b1, 40, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("hold_latency", lat, 11);
    chk("hold_clear_count", clr_cnt, 1);
    check_c();
    @(negedge clock_i);
    chk("hold_idle_busy", busy_o, 0);
    chk("hold_idle_clear", mac_clear_o, 0);
    @(negedge clock_i);
    chk("hold_second_clear", mac_clear_o, 1);
    start_i = 1'b0;
    lat2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock_i);
      if (done_o) begin
        lat2 = i;
        break;
      end
    end
    chk("hold_second_latency", lat2, 10);
    check_c();

    // reset in the middle of FEED
    @(negedge clock_i);
    start_i = 1'b1;
    k_len_i = K_W'(8);
    found   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_i);
      start_i = 1'b0;
      if (mem_rd_en_o && mem_rd_addr_o == K_W'(3)) begin
        found = 1'b1;
        break;
      end
    end
    chk("midfeed_reached", found, 1);
    resetn_i = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clock_i);
    resetn_i = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_i);
      if (done_o) done_seen++;
    end
    chk("midreset_no_done", done_seen, 0);
    push_expected(1);
    run_tile(1, 1'b0, 40, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("after_reset_latency", lat, 11);
    check_c();

    // K=8 -> 1+8+8+1 = 18 cycles
    push_expected(8);
    run_tile(8, 1'b0, 60, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("k8_latency", lat, 18);
    chk("k8_rd_count", rd_cnt, 8);
    check_c();
    @(negedge clock_i);
`ifdef SYSTOLIC_PERF_CNT_EN
    chk("k8_cycles_o", cycles_o, 18);
`endif

    // K above maximum saturates to 256
    push_expected(256);
    run_tile(300, 1'b0, 400, lat, rd_cnt, clr_cnt, first_rd, first_a3);
    chk("ksat_latency", lat, 266);
    chk("ksat_rd_count", rd_cnt, 256);
    check_c();
    @(negedge clock_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
